// File: rtl/vending_change_dispenser_if.sv
// Change-request channel from the vending FSM: amount offered with valid, taken on valid & ready.
// Zero latency; the master holds valid and amount until ready, and ready is high only while the dispenser is idle.
interface vending_change_dispenser_if #(
  parameter int AMT_W = 8
) ();
  logic             req_valid;
  logic [AMT_W-1:0] req_amount;
  logic             req_ready;

  modport master (
    output req_valid,
    output req_amount,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_amount,
    output req_ready
  );
endinterface

// File: rtl/vending_change_dispenser.sv
// Change payout sequencer: largest coin first, PULSE_LEN-tick eject pulse, GAP_LEN-tick gap; DISPENSE_COUNT_EN adds big/small coin counters.
// All outputs registered (one clock after the deciding edge); req_ready only in IDLE, requests arriving while busy are simply not taken.
module vending_change_dispenser #(
  parameter int AMT_W     = 8,
  parameter int BIG_VAL   = 5,
  parameter int SMALL_VAL = 1,
  parameter int PULSE_LEN = 3,
  parameter int GAP_LEN   = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 tick,
  vending_change_dispenser_if.slave req,
  input  logic                 big_empty,
  input  logic                 small_empty,
  input  logic                 abort,
  input  logic                 fault_clr,
  output logic                 coin_big,
  output logic                 coin_small,
  output logic                 busy,
  output logic                 done,
  output logic                 fault,
  output logic [AMT_W-1:0]     remaining
`ifdef DISPENSE_COUNT_EN
  ,
  output logic [7:0]           big_count,
  output logic [7:0]           small_count
`endif
);

  localparam int TMAX  = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
  localparam int CNT_W = ($clog2(TMAX) < 1) ? 1 : $clog2(TMAX);

  localparam logic [AMT_W-1:0] BIG_AMT    = AMT_W'(BIG_VAL);
  localparam logic [AMT_W-1:0] SMALL_AMT  = AMT_W'(SMALL_VAL);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_PULSE,
    S_GAP,
    S_DONE,
    S_FAULT
  } state_t;

  state_t           state_q, state_d;
  logic             sel_big_q, sel_big_d;
  logic [CNT_W-1:0] tcnt_q, tcnt_d;
  logic [AMT_W-1:0] remaining_q, remaining_d;
  logic             coin_big_q, coin_big_d;
  logic             coin_small_q, coin_small_d;
  logic             req_ready_q, req_ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fault_q, fault_d;

  logic             accept;
  logic             pulse_end;
  logic             gap_end;
  logic [AMT_W-1:0] coin_val;

  assign accept    = req.req_valid && req_ready_q;
  assign pulse_end = (state_q == S_PULSE) && tick && (tcnt_q == PULSE_LAST);
  assign gap_end   = (state_q == S_GAP) && tick && (tcnt_q == GAP_LAST);
  assign coin_val  = sel_big_q ? BIG_AMT : SMALL_AMT;

  always_comb begin
    state_d     = state_q;
    sel_big_d   = sel_big_q;
    tcnt_d      = tcnt_q;
    remaining_d = remaining_q;

    // Abort drops straight to IDLE; a coin cut mid-pulse is not deducted.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      tcnt_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            remaining_d = req.req_amount;
            state_d     = S_SELECT;
          end
        end
        S_SELECT: begin
          tcnt_d = '0;
          if ((remaining_q >= BIG_AMT) && !big_empty) begin
            sel_big_d = 1'b1;
            state_d   = S_PULSE;
          end else if ((remaining_q >= SMALL_AMT) && !small_empty) begin
            sel_big_d = 1'b0;
            state_d   = S_PULSE;
          end else if (remaining_q < SMALL_AMT) begin
            state_d = S_DONE;
          end else begin
            state_d = S_FAULT;
          end
        end
        S_PULSE: begin
          if (pulse_end) begin
            tcnt_d      = '0;
            remaining_d = remaining_q - coin_val;
            state_d     = S_GAP;
          end else if (tick) begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
        S_GAP: begin
          if (gap_end) begin
            tcnt_d  = '0;
            state_d = S_SELECT;
          end else if (tick) begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        S_FAULT: begin
          if (fault_clr) begin
            state_d = S_SELECT;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    coin_big_d   = (state_d == S_PULSE) && sel_big_d;
    coin_small_d = (state_d == S_PULSE) && !sel_big_d;
    req_ready_d  = (state_d == S_IDLE);
    busy_d       = (state_d != S_IDLE);
    done_d       = (state_d == S_DONE);
    fault_d      = (state_d == S_FAULT);
  end

`ifdef DISPENSE_COUNT_EN
  logic [7:0] big_count_q, big_count_d;
  logic [7:0] small_count_q, small_count_d;
  logic       coin_complete;

  assign coin_complete = pulse_end && !abort;

  always_comb begin
    big_count_d   = big_count_q;
    small_count_d = small_count_q;
    if (coin_complete && sel_big_q && (big_count_q != 8'hFF)) begin
      big_count_d = big_count_q + 8'd1;
    end
    if (coin_complete && !sel_big_q && (small_count_q != 8'hFF)) begin
      small_count_d = small_count_q + 8'd1;
    end
  end

  assign big_count   = big_count_q;
  assign small_count = small_count_q;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      sel_big_q     <= 1'b0;
      tcnt_q        <= '0;
      remaining_q   <= '0;
      coin_big_q    <= 1'b0;
      coin_small_q  <= 1'b0;
      req_ready_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      fault_q       <= 1'b0;
`ifdef DISPENSE_COUNT_EN
      big_count_q   <= '0;
      small_count_q <= '0;
`endif
    end else begin
      state_q       <= state_d;
      sel_big_q     <= sel_big_d;
      tcnt_q        <= tcnt_d;
      remaining_q   <= remaining_d;
      coin_big_q    <= coin_big_d;
      coin_small_q  <= coin_small_d;
      req_ready_q   <= req_ready_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      fault_q       <= fault_d;
`ifdef DISPENSE_COUNT_EN
      big_count_q   <= big_count_d;
      small_count_q <= small_count_d;
`endif
    end
  end

  assign req.req_ready = req_ready_q;
  assign coin_big      = coin_big_q;
  assign coin_small    = coin_small_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign fault         = fault_q;
  assign remaining     = remaining_q;

endmodule
